sirv_gnrl_skid_buf: RTL and testbench

- Two-entry valid/ready elastic stage for the sirv_gnrl library.
- It is the handshaking counterpart to the team's plain reset-DFF. It sits between a producer and a consumer and cuts every combinational path between them: o_rdy never reaches i_rdy, and i_vld/i_dat never reach o_vld/o_dat.
- It is used to register long valid/ready interfaces between pipeline stages without losing throughput.

---
 rtl/sirv_gnrl_pkg.sv | 18 +
 rtl/sirv_gnrl_skid_ctrl.sv | 72 +++++++
 rtl/sirv_gnrl_skid_buf.sv | 52 +++++
 tb/tb_sirv_gnrl_skid_buf.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sirv_gnrl_pkg.sv
// Shared types and handshake helpers for the sirv_gnrl valid/ready library.
// The skid-buffer state encoding doubles as its occupancy count.
package sirv_gnrl_pkg;

  localparam int unsigned CNT_W = 2;

  typedef enum logic [CNT_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // A beat moves only when both sides agree in the same cycle.
  function automatic logic hs_fire(input logic vld, input logic rdy);
    return vld & rdy;
  endfunction

endpackage

// File: rtl/sirv_gnrl_skid_ctrl.sv
// Occupancy state machine for the two-entry skid buffer; produces the load
// enables for the main and skid data registers.
module sirv_gnrl_skid_ctrl
  import sirv_gnrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_vld,
  input  logic             o_rdy,
  output logic             i_rdy,
  output logic             o_vld,
  output logic [CNT_W-1:0] o_cnt,
  output logic             ld_main,
  output logic             sel_skid,
  output logic             ld_skid
);

  skid_state_e state_q, state_d;
  logic        in_hs, out_hs;

  // Handshake outputs come from the state register alone, which keeps
  // o_rdy off the i_rdy path and i_vld off the o_vld path.
  assign i_rdy    = (state_q != FULL);
  assign o_vld    = (state_q != EMPTY);
  assign o_cnt    = state_q;
  assign sel_skid = (state_q == FULL);
  assign in_hs    = hs_fire(i_vld, i_rdy);
  assign out_hs   = hs_fire(o_vld, o_rdy);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    case (state_q)
      EMPTY: if (in_hs) begin
        ld_main = 1'b1;
        state_d = BUSY;
      end
      BUSY: case ({in_hs, out_hs})
        2'b11: ld_main = 1'b1;
        2'b10: begin
          ld_skid = 1'b1;
          state_d = FULL;
        end
        2'b01: state_d = EMPTY;
        default: state_d = BUSY;
      endcase
      FULL: if (out_hs) begin
        ld_main = 1'b1;
        state_d = BUSY;
      end
      default: state_d = EMPTY;
    endcase
    // Flush completes any handshake but drops the beat and keeps the data.
    if (flush) begin
      state_d = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/sirv_gnrl_skid_buf.sv
// Two-entry valid/ready elastic stage: fully registered in both directions,
// sustaining one beat per cycle with strict FIFO ordering.
module sirv_gnrl_skid_buf
  import sirv_gnrl_pkg::*;
#(
  parameter int unsigned    DW      = 32,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [DW-1:0]    i_dat,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [DW-1:0]    o_dat,
  output logic [CNT_W-1:0] o_cnt
);

  logic          ld_main, sel_skid, ld_skid;
  logic [DW-1:0] main_q, skid_q;

  sirv_gnrl_skid_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .i_vld    (i_vld),
    .o_rdy    (o_rdy),
    .i_rdy    (i_rdy),
    .o_vld    (o_vld),
    .o_cnt    (o_cnt),
    .ld_main  (ld_main),
    .sel_skid (sel_skid),
    .ld_skid  (ld_skid)
  );

  // NOTE: the payload registers are reset too, so o_dat shows a known
  // RST_VAL after reset instead of whatever beat was in flight.
  always_ff @(posedge clk) begin
    if (rst)          main_q <= RST_VAL;
    else if (ld_main) main_q <= sel_skid ? skid_q : i_dat;
  end

  always_ff @(posedge clk) begin
    if (rst)          skid_q <= RST_VAL;
    else if (ld_skid) skid_q <= i_dat;
  end

  assign o_dat = main_q;

endmodule

// File: tb/tb_sirv_gnrl_skid_buf.sv
// Directed bench for sirv_gnrl_skid_buf with DW=8 and hand-computed expectations.
module tb_sirv_gnrl_skid_buf;

  logic       clk = 1'b0;
  logic       rst, flush, i_vld, o_rdy;
  logic       i_rdy, o_vld;
  logic [7:0] i_dat, o_dat;
  logic [1:0] o_cnt;

  int passed = 0;
  int total  = 0;

  sirv_gnrl_skid_buf #(.DW(8), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_cnt (o_cnt)
  );

  always #5 clk = ~clk;

  // Inputs are applied 1 time unit after a rising edge, so they are stable
  // at the falling edge where these properties are sampled.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_dat;
  always @(negedge clk) begin
    if (prev_hold) begin
      assert (o_vld === 1'b1 && o_dat === prev_dat)
        else $error("FAIL stable: o_vld=%b o_dat=%h want 1 %h", o_vld, o_dat, prev_dat);
    end
    assert (o_cnt !== 2'd3) else $error("FAIL cnt_range: o_cnt=3");
    if (i_rdy === 1'b0)
      assert (o_cnt === 2'd2) else $error("FAIL rdy_full: i_rdy=0 with o_cnt=%0d", o_cnt);
    prev_hold = (o_vld === 1'b1) && (o_rdy === 1'b0) && (rst === 1'b0) && (flush === 1'b0);
    prev_dat  = o_dat;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0; i_dat = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; i_dat = 8'hEE;
    step(); step();
    rst = 1'b0;
    total++; if (o_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", o_vld); else passed++;
    total++; if (i_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", i_rdy); else passed++;
    total++; if (o_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", o_cnt); else passed++;
    total++; if (o_dat !== 8'h00) $display("FAIL reset_dat: got %h want 00", o_dat); else passed++;
    step(); step(); step();
    total++; if (o_cnt !== 2'd0 || o_vld !== 1'b0)
      $display("FAIL idle: cnt=%0d vld=%b want 0 0", o_cnt, o_vld); else passed++;
  endtask

  task automatic test_streaming();
    logic [7:0] beats [3] = '{8'h11, 8'h22, 8'h33};
    o_rdy = 1'b1; i_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_dat = beats[i];
      step();
      total++; if (o_dat !== beats[i] || o_vld !== 1'b1)
        $display("FAIL stream_dat%0d: got %h/%b want %h/1", i, o_dat, o_vld, beats[i]); else passed++;
      total++; if (o_cnt !== 2'd1 || i_rdy !== 1'b1)
        $display("FAIL stream_cnt%0d: got cnt=%0d rdy=%b want 1 1", i, o_cnt, i_rdy); else passed++;
    end
    i_vld = 1'b0;
    step();
    total++; if (o_cnt !== 2'd0 || o_vld !== 1'b0)
      $display("FAIL stream_end: cnt=%0d vld=%b want 0 0", o_cnt, o_vld); else passed++;
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    o_rdy = 1'b0; i_vld = 1'b1;
    i_dat = a; step();
    i_dat = b; step();
    i_vld = 1'b0;
  endtask

  task automatic test_backpressure();
    o_rdy = 1'b0; i_vld = 1'b1; i_dat = 8'hA1;
    step();
    total++; if (o_cnt !== 2'd1 || o_dat !== 8'hA1 || i_rdy !== 1'b1)
      $display("FAIL bp_first: cnt=%0d dat=%h rdy=%b want 1 a1 1", o_cnt, o_dat, i_rdy); else passed++;
    i_dat = 8'hA2;
    step();
    total++; if (o_cnt !== 2'd2 || i_rdy !== 1'b0 || o_dat !== 8'hA1)
      $display("FAIL bp_full: cnt=%0d rdy=%b dat=%h want 2 0 a1", o_cnt, i_rdy, o_dat); else passed++;
    i_dat = 8'hA3;
    step();
    i_vld = 1'b0;
    total++; if (o_cnt !== 2'd2 || o_dat !== 8'hA1)
      $display("FAIL bp_reject: cnt=%0d dat=%h want 2 a1", o_cnt, o_dat); else passed++;
  endtask

  task automatic test_drain();
    o_rdy = 1'b1;
    total++; if (o_dat !== 8'hA1 || o_vld !== 1'b1)
      $display("FAIL drain_first: dat=%h vld=%b want a1 1", o_dat, o_vld); else passed++;
    step();
    total++; if (o_dat !== 8'hA2 || o_cnt !== 2'd1 || i_rdy !== 1'b1)
      $display("FAIL drain_second: dat=%h cnt=%0d rdy=%b want a2 1 1", o_dat, o_cnt, i_rdy); else passed++;
    step();
    total++; if (o_cnt !== 2'd0 || o_vld !== 1'b0)
      $display("FAIL drain_empty: cnt=%0d vld=%b want 0 0", o_cnt, o_vld); else passed++;
  endtask

  task automatic test_order();
    // Input keeps flowing while the consumer stalls once; the skid beat must
    // come out before the newer one.
    o_rdy = 1'b0; i_vld = 1'b1; i_dat = 8'hC0; step();
    i_dat = 8'hC1; step();
    o_rdy = 1'b1; i_dat = 8'hC2; step();
    total++; if (o_dat !== 8'hC1 || o_cnt !== 2'd1)
      $display("FAIL order_skid: dat=%h cnt=%0d want c1 1", o_dat, o_cnt); else passed++;
    step();
    i_vld = 1'b0;
    total++; if (o_dat !== 8'hC2 || o_cnt !== 2'd1)
      $display("FAIL order_next: dat=%h cnt=%0d want c2 1", o_dat, o_cnt); else passed++;
    step();
    total++; if (o_vld !== 1'b0) $display("FAIL order_empty: vld=%b want 0", o_vld); else passed++;
  endtask

  task automatic test_flush();
    fill(8'hB1, 8'hB2);
    total++; if (o_cnt !== 2'd2) $display("FAIL flush_pre: cnt=%0d want 2", o_cnt); else passed++;
    flush = 1'b1; i_vld = 1'b1; i_dat = 8'h55;
    step();
    flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b1;
    total++; if (o_vld !== 1'b0 || o_cnt !== 2'd0 || i_rdy !== 1'b1)
      $display("FAIL flush_full: vld=%b cnt=%0d rdy=%b want 0 0 1", o_vld, o_cnt, i_rdy); else passed++;
    step(); step();
    total++; if (o_vld !== 1'b0) $display("FAIL flush_nodeliver: vld=%b want 0", o_vld); else passed++;
    // Flush while BUSY with both handshakes live: the incoming beat is dropped.
    i_vld = 1'b1; i_dat = 8'h66; step();
    flush = 1'b1; i_dat = 8'h77; step();
    flush = 1'b0; i_vld = 1'b0;
    total++; if (o_cnt !== 2'd0 || o_dat !== 8'h66)
      $display("FAIL flush_busy: cnt=%0d dat=%h want 0 66", o_cnt, o_dat); else passed++;
    // Flush in EMPTY is a no-op and still drops any offered beat.
    flush = 1'b1; i_vld = 1'b1; i_dat = 8'h88; step();
    flush = 1'b0; i_vld = 1'b0;
    total++; if (o_cnt !== 2'd0 || o_dat !== 8'h66)
      $display("FAIL flush_empty: cnt=%0d dat=%h want 0 66", o_cnt, o_dat); else passed++;
  endtask

  task automatic test_reset_mid();
    fill(8'hD1, 8'hD2);
    total++; if (o_cnt !== 2'd2) $display("FAIL rstmid_pre: cnt=%0d want 2", o_cnt); else passed++;
    rst = 1'b1; o_rdy = 1'b1; i_vld = 1'b1; i_dat = 8'hD3;
    step();
    rst = 1'b0; i_vld = 1'b0;
    total++; if (o_vld !== 1'b0 || i_rdy !== 1'b1 || o_dat !== 8'h00 || o_cnt !== 2'd0)
      $display("FAIL rstmid: vld=%b rdy=%b dat=%h cnt=%0d want 0 1 00 0", o_vld, i_rdy, o_dat, o_cnt); else passed++;
    o_rdy = 1'b0; step();
    o_rdy = 1'b1; step();
    total++; if (o_vld !== 1'b0) $display("FAIL rstmid_stale: vld=%b want 0", o_vld); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain();
    test_order();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
